// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: in-order circular buffer of {PC+4, instruction} pairs
// between fetch and decode; freezes fetch when full and drops everything on a taken branch.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] instruction_in,
  input  logic             flush,
  input  logic             id_ready,
  output logic             if_stall,
  output logic             valid_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] instruction_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [WIDTH-1:0] instr_mem_q [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = if_valid & ~full & ~flush;
  assign pop   = ~empty & id_ready & ~flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload is never cleared; stale entries are hidden by the valid_out mask below.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      pc_mem_q[tail_q]    <= pc_in;
      instr_mem_q[tail_q] <= instruction_in;
    end
  end

  assign if_stall        = full;
  assign valid_out       = ~empty;
  assign pc_out          = valid_out ? pc_mem_q[head_q]    : '0;
  assign instruction_out = valid_out ? instr_mem_q[head_q] : '0;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed vector table, wrap-around stream,
// and randomized traffic against a queue-based reference model.
module tb_if_id_queue;

  localparam int DEPTH = 2;
  localparam int WIDTH = 32;

  localparam logic [31:0] I1  = 32'hE3A00001;
  localparam logic [31:0] I2  = 32'hE3A00002;
  localparam logic [31:0] I3  = 32'hE3A00003;
  localparam logic [31:0] I4  = 32'hE3A00004;
  localparam logic [31:0] I5  = 32'hE3A00005;
  localparam logic [31:0] IBR = 32'hEAFFFFFE;

  logic             clk = 1'b0;
  logic             rst;
  logic             if_valid;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] instruction_in;
  logic             flush;
  logic             id_ready;
  logic             if_stall;
  logic             valid_out;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] instruction_out;

  int total = 0;
  int bad   = 0;

  logic [63:0] mq[$];

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_valid        (if_valid),
    .pc_in           (pc_in),
    .instruction_in  (instruction_in),
    .flush           (flush),
    .id_ready        (id_ready),
    .if_stall        (if_stall),
    .valid_out       (valid_out),
    .pc_out          (pc_out),
    .instruction_out (instruction_out)
  );

  typedef struct {
    logic        r;
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        f;
    logic        rd;
    logic        ev;
    logic        es;
    logic [31:0] epc;
    logic [31:0] eins;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: a plain FIFO of at most DEPTH pairs, updated from pre-edge occupancy.
  task automatic model_step();
    bit was_full;
    bit do_pop;
    bit do_push;
    was_full = (mq.size() == DEPTH);
    if (!rst || flush) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() > 0) && id_ready;
      do_push = if_valid && !was_full;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({pc_in, instruction_in});
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [31:0] pc,
                       input logic [31:0] ins, input logic f, input logic rd);
    logic [63:0] head;
    rst = r; if_valid = v; pc_in = pc; instruction_in = ins; flush = f; id_ready = rd;
    @(posedge clk);
    #1;
    model_step();
    head = (mq.size() > 0) ? mq[0] : 64'h0;
    chk("mdl_valid", 32'(valid_out), 32'(mq.size() > 0));
    chk("mdl_stall", 32'(if_stall), 32'(mq.size() == DEPTH));
    chk("mdl_pc", pc_out, head[63:32]);
    chk("mdl_instr", instruction_out, head[31:0]);
  endtask

  initial begin : main
    vec_t        tbl[24];
    logic [63:0] got[$];
    bit          pat[5];
    int          idx;
    int          cyc;
    logic        rd;
    logic        adv;
    logic [63:0] item;

    rst = 1'b0; if_valid = 1'b0; pc_in = '0; instruction_in = '0; flush = 1'b0; id_ready = 1'b0;

    tbl = '{
      //  r  v   pc         ins  f  rd   ev es  epc        eins
      '{0, 1, 32'h4,   I1,  0, 0,   0, 0, 32'h0,   32'h0},  // reset held, input ignored
      '{0, 1, 32'h4,   I1,  0, 0,   0, 0, 32'h0,   32'h0},
      '{1, 1, 32'h4,   I1,  0, 0,   1, 0, 32'h4,   I1},     // first push, one-cycle latency
      '{1, 1, 32'h8,   I2,  0, 1,   1, 0, 32'h8,   I2},     // push+pop at count 1
      '{1, 0, 32'h0,   32'h0, 0, 1, 0, 0, 32'h0,   32'h0},
      '{1, 1, 32'h4,   I1,  0, 0,   1, 0, 32'h4,   I1},     // fill to full
      '{1, 1, 32'h8,   I2,  0, 0,   1, 1, 32'h4,   I1},
      '{1, 1, 32'hC,   I3,  0, 0,   1, 1, 32'h4,   I1},     // ignored while full
      '{1, 1, 32'hC,   I3,  0, 0,   1, 1, 32'h4,   I1},
      '{1, 1, 32'hC,   I3,  0, 0,   1, 1, 32'h4,   I1},
      '{1, 1, 32'hC,   I3,  0, 1,   1, 0, 32'h8,   I2},     // pop only: was full
      '{1, 1, 32'hC,   I3,  0, 1,   1, 0, 32'hC,   I3},
      '{1, 0, 32'h0,   32'h0, 0, 1, 0, 0, 32'h0,   32'h0},
      '{1, 1, 32'h4,   I1,  0, 0,   1, 0, 32'h4,   I1},     // flush while full
      '{1, 1, 32'h8,   I2,  0, 0,   1, 1, 32'h4,   I1},
      '{1, 1, 32'hC,   I3,  1, 1,   0, 0, 32'h0,   32'h0},
      '{1, 1, 32'h104, IBR, 0, 0,   1, 0, 32'h104, IBR},
      '{1, 0, 32'h0,   32'h0, 0, 1, 0, 0, 32'h0,   32'h0},
      '{1, 1, 32'h4,   I1,  0, 0,   1, 0, 32'h4,   I1},     // reset beats flush mid-operation
      '{1, 1, 32'h8,   I2,  0, 0,   1, 1, 32'h4,   I1},
      '{0, 1, 32'hC,   I3,  1, 1,   0, 0, 32'h0,   32'h0},
      '{1, 1, 32'h10,  I4,  0, 0,   1, 0, 32'h10,  I4},
      '{1, 1, 32'h14,  I5,  0, 1,   1, 0, 32'h14,  I5},
      '{1, 0, 32'h0,   32'h0, 0, 1, 0, 0, 32'h0,   32'h0}
    };

    for (int i = 0; i < 24; i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].pc, tbl[i].ins, tbl[i].f, tbl[i].rd);
      chk($sformatf("tbl%0d_valid", i), 32'(valid_out), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_stall", i), 32'(if_stall), 32'(tbl[i].es));
      chk($sformatf("tbl%0d_pc", i), pc_out, tbl[i].epc);
      chk($sformatf("tbl%0d_instr", i), instruction_out, tbl[i].eins);
    end

    // Wrap-around stream: fetch re-presents each word until the queue has room.
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    idx = 0;
    cyc = 0;
    while ((idx < 10 || mq.size() > 0) && cyc < 80) begin
      rd  = pat[cyc % 5];
      adv = (idx < 10) && (mq.size() < DEPTH);
      if (mq.size() > 0 && rd) got.push_back({pc_out, instruction_out});
      cycle(1'b1, idx < 10, 32'((idx + 1) * 4), 32'(idx + 1), 1'b0, rd);
      if (adv) idx++;
      cyc++;
    end
    chk("wrap_count", 32'(got.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      item = (k < got.size()) ? got[k] : 64'hFFFF_FFFF_FFFF_FFFF;
      chk($sformatf("wrap%0d_pc", k), item[63:32], 32'((k + 1) * 4));
      chk($sformatf("wrap%0d_instr", k), item[31:0], 32'(k + 1));
    end

    // Randomized traffic against the reference FIFO.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), $urandom, $urandom,
            ($urandom_range(0, 11) == 0), $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling buffer between the instruction-fetch stage and the instruction-decode stage.
- Captures each fetched {PC+4, instruction} pair into a small in-order circular queue and presents the oldest entry to decode.
- Drives the fetch-stage freeze when the queue is full.
- Discards all buffered and in-flight wrong-path instructions when a branch is taken.

Parameters:
- DEPTH, 2, number of queue entries; power of two, minimum 2.
- WIDTH, 32, width of the PC and instruction fields.

Ports:
- clk  input  1  pipeline clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- if_valid  input  1  fetch stage presents a valid pair this cycle.
- pc_in  input  WIDTH  PC+4 from the fetch stage.
- instruction_in  input  WIDTH  instruction word from the fetch stage.
- flush  input  1  branch taken; connects to the fetch stage's branchTaken.
- id_ready  input  1  decode stage accepts the head entry this cycle; low during hazard freeze.
- if_stall  output  1  queue full; connects to the fetch stage's freeze.
- valid_out  output  1  head entry valid.
- pc_out  output  WIDTH  PC+4 of the head entry.
- instruction_out  output  WIDTH  instruction of the head entry.

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset is synchronous and active-low: rst=0 at a rising edge of clk clears state.
  - Reset state: head=0, tail=0, count=0, valid_out=0, if_stall=0, pc_out=0, instruction_out=0.
  - Reset has priority over every other input.
- State:
  - Storage: DEPTH entries of {pc, instruction}.
  - Pointers: head and tail, each clog2(DEPTH) bits, wrapping naturally modulo DEPTH.
  - count: clog2(DEPTH)+1 bits, range 0..DEPTH.
- Status flags:
  - full = (count==DEPTH).
  - empty = (count==0).
- Outputs:
  - if_stall = full. Combinational from count only; no dependence on id_ready or if_valid, so there is no combinational path from decode back to fetch.
  - valid_out = ~empty.
  - pc_out and instruction_out = storage[head] when valid_out=1; otherwise forced to 0. Instruction 0 is treated as NOP downstream.
- Push:
  - push = if_valid & ~full & ~flush.
  - On push, storage[tail] is written and tail increments.
  - When full, a push attempt is ignored. Fetch is frozen in that state, so the data is re-presented.
- Pop:
  - pop = valid_out & id_ready & ~flush.
  - On pop, head increments.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: count is unchanged and both pointers advance. This is legal at any count from 1 to DEPTH-1.
- Latency and ordering:
  - A pair pushed at edge N is visible on the outputs after edge N, i.e. one cycle of latency.
  - Empty pass-through is not allowed: a pair presented while the queue is empty does not appear on the outputs in the same cycle.
  - Entries leave in strict FIFO order.
- Flush:
  - On flush=1 at an edge (with rst=1): head=tail=0 and count=0.
  - The same-cycle push and pop are both suppressed.
  - The next cycle shows valid_out=0 and if_stall=0, so fetch of the branch target resumes immediately.
  - Flush while full or while id_ready=0 behaves identically.
- Stall interaction: id_ready=0 holds the head entry and its outputs stable for any number of cycles. Pushes continue until full.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble. Order is preserved across the wrap.
- Priority at an edge: rst > flush > push/pop.
- Storage contents are not cleared by reset or flush; only pointers and count are. Stale data is never visible because the outputs are masked by valid_out.

Test Plan:
- Reset: hold rst=0 for 2 cycles with if_valid=1 and pc_in=0x4 -> valid_out=0, if_stall=0, pc_out=0, instruction_out=0. After release, the first push of {0x4, 0xE3A00001} appears on the outputs exactly one cycle later.
- Fill to full (DEPTH=2): id_ready=0, push {0x4,I1} then {0x8,I2} -> if_stall=1 after the second edge. Present {0xC,I3} for 3 cycles -> ignored. Set id_ready=1 -> outputs I1, then I2, then I3 (I3 re-presented by fetch), with no loss or duplication.
- Simultaneous push/pop: count=1 holding {0x4,I1}, if_valid=1 with {0x8,I2}, id_ready=1 -> count stays 1, outputs switch to {0x8,I2}, if_stall remains 0.
- Flush: queue full with I1 and I2, assert flush together with if_valid={0xC,I3} and id_ready=1 -> next cycle valid_out=0, if_stall=0, instruction_out=0. I3 is never output. A subsequent push of {0x104,Ibr} is output next.
- Wrap-around: stream 10 instructions 0x1..0xA at PCs 0x4..0x28 with id_ready toggling 1,0,1,1,0,… -> the output sequence is exactly 0x1..0xA in order with matching PCs, no drops and no repeats.
- Reset mid-operation: count=2 and flush=1 in the same cycle as rst=0 -> reset values on the next cycle. Push and pop resume correctly after rst returns to 1.
